// File: rtl/data_access_unit_pkg.sv
// Shared definitions for the data access unit: store/load type codes, access sizes, FSM states.
package data_access_unit_pkg;

    typedef enum logic [2:0] {
        ST_SW  = 3'b000,
        ST_SB  = 3'b001,
        ST_SH  = 3'b010,
        ST_SWL = 3'b011,
        ST_SWR = 3'b100
    } store_type_e;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LH  = 3'b010,
        LT_LWL = 3'b011,
        LT_LWR = 3'b100,
        LT_LBU = 3'b101,
        LT_LHU = 3'b110
    } load_type_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Byte and halfword stores carry the unaligned address; word-class stores are word aligned.
    function automatic logic store_full_addr(input logic [2:0] st);
        return (st == ST_SB) || (st == ST_SH);
    endfunction

endpackage

// File: rtl/data_access_unit_store_align.sv
// Store alignment: derives access size, byte strobes and lane-shifted write data per store type.
module store_align
    import data_access_unit_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rt,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_size  = SIZE_WORD;
        o_wstrb = 4'b1111;
        o_wdata = i_rt;
        case (i_type)
            ST_SB: begin
                o_size  = SIZE_BYTE;
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rt[7:0]}};
            end
            ST_SH: begin
                o_size  = SIZE_HALF;
                o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_rt[15:0]}};
            end
            ST_SWL: begin
                case (i_addr_lo)
                    2'b00: begin o_wstrb = 4'b0001; o_wdata = {24'b0, i_rt[31:24]}; end
                    2'b01: begin o_wstrb = 4'b0011; o_wdata = {16'b0, i_rt[31:16]}; end
                    2'b10: begin o_wstrb = 4'b0111; o_wdata = {8'b0, i_rt[31:8]};   end
                    default: begin o_wstrb = 4'b1111; o_wdata = i_rt;               end
                endcase
            end
            ST_SWR: begin
                case (i_addr_lo)
                    2'b00: begin o_wstrb = 4'b1111; o_wdata = i_rt;                 end
                    2'b01: begin o_wstrb = 4'b1110; o_wdata = {i_rt[23:0], 8'b0};   end
                    2'b10: begin o_wstrb = 4'b1100; o_wdata = {i_rt[15:0], 16'b0};  end
                    default: begin o_wstrb = 4'b1000; o_wdata = {i_rt[7:0], 24'b0}; end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_access_unit.sv
// Data-RAM access unit: issues load/store requests over a req/addr_ok/data_ok port and stalls the pipe.
// Optional ADDR_ERR_CHECK_EN adds misalignment detection (exe_Load_type in, mem_addr_err out).
module data_access_unit
    import data_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_Abortion,
    input  logic              pipe_stall,
    input  logic              exe_out_Mem_read,
    input  logic              exe_out_Mem_write,
    input  logic [2:0]        exe_Store_type,
    input  logic [ADDR_W-1:0] exe_ALU_out,
    input  logic [DATA_W-1:0] exe_rdata2,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] mem_in_data,
    output logic              data_wait
`ifdef ADDR_ERR_CHECK_EN
    ,
    input  logic [2:0]        exe_Load_type,
    output logic              mem_addr_err
`endif
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_discard;
    logic              w_discard_nxt;
    logic              w_access;
    logic              w_misaligned;
    logic              w_issue;
    logic              w_launch;
    logic              w_complete;
    logic              w_capture;
    logic              w_wr;
    logic [1:0]        w_st_size;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_st_wdata;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_addr;

    assign w_access = exe_valid & (exe_out_Mem_read | exe_out_Mem_write) & ~exe_Abortion;
    assign w_issue  = w_access & ~w_misaligned;
    assign w_wr     = exe_out_Mem_write & ~exe_out_Mem_read;

    store_align u_store_align (
        .i_type    (exe_Store_type),
        .i_addr_lo (exe_ALU_out[1:0]),
        .i_rt      (exe_rdata2),
        .o_size    (w_st_size),
        .o_wstrb   (w_st_wstrb),
        .o_wdata   (w_st_wdata)
    );

    always_comb begin
        w_size  = SIZE_WORD;
        w_wstrb = '0;
        w_wdata = '0;
        w_addr  = {exe_ALU_out[ADDR_W-1:2], 2'b00};
        if (w_wr) begin
            w_size  = w_st_size;
            w_wstrb = w_st_wstrb;
            w_wdata = w_st_wdata;
            if (store_full_addr(exe_Store_type)) begin
                w_addr = exe_ALU_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // An abort after addr_ok cannot cancel the bus transfer; r_discard remembers to drop its result.
    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        w_launch      = 1'b0;
        data_wait     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_discard_nxt = 1'b0;
                data_wait     = w_issue;
                if (w_issue) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                data_wait = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        data_wait   = 1'b0;
                        w_state_nxt = (pipe_stall & ~exe_Abortion) ? S_DONE : S_IDLE;
                    end else begin
                        w_state_nxt   = S_WAIT;
                        w_discard_nxt = exe_Abortion;
                    end
                end else if (exe_Abortion) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                data_wait = 1'b1;
                if (exe_Abortion) begin
                    w_discard_nxt = 1'b1;
                end
                if (data_data_ok) begin
                    data_wait     = 1'b0;
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = (pipe_stall & ~(r_discard | exe_Abortion)) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (!pipe_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_complete = ((r_state == S_REQ) & data_addr_ok & data_data_ok) |
                        ((r_state == S_WAIT) & data_data_ok);
    assign w_capture  = w_complete & ~data_wr & ~(r_discard | exe_Abortion);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= '0;
            data_addr   <= '0;
            data_wstrb  <= '0;
            data_wdata  <= '0;
            mem_in_data <= '0;
        end else begin
            if (w_launch) begin
                data_req   <= 1'b1;
                data_wr    <= w_wr;
                data_size  <= w_size;
                data_addr  <= w_addr;
                data_wstrb <= w_wstrb;
                data_wdata <= w_wdata;
            end else if ((r_state == S_REQ) && (data_addr_ok || exe_Abortion)) begin
                data_req <= 1'b0;
            end
            if (w_capture) begin
                mem_in_data <= data_rdata;
            end
        end
    end

`ifdef ADDR_ERR_CHECK_EN
    logic r_addr_err;

    assign w_misaligned = w_access & (exe_out_Mem_read ?
        (((exe_Load_type == LT_LW) & (exe_ALU_out[1:0] != 2'b00)) |
         (((exe_Load_type == LT_LH) | (exe_Load_type == LT_LHU)) & exe_ALU_out[0])) :
        (((exe_Store_type == ST_SW) & (exe_ALU_out[1:0] != 2'b00)) |
         ((exe_Store_type == ST_SH) & exe_ALU_out[0])));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= (r_state == S_IDLE) & w_misaligned;
        end
    end

    assign mem_addr_err = r_addr_err;
`else
    assign w_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_data_access_unit.sv
// Directed bench for data_access_unit: table of load/store vectors plus handshake corner sequences.
module tb_data_access_unit;
    import data_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        exe_Abortion;
    logic        pipe_stall;
    logic        exe_out_Mem_read;
    logic        exe_out_Mem_write;
    logic [2:0]  exe_Store_type;
    logic [31:0] exe_ALU_out;
    logic [31:0] exe_rdata2;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] mem_in_data;
    logic        data_wait;
`ifdef ADDR_ERR_CHECK_EN
    logic [2:0]  exe_Load_type;
    logic        mem_addr_err;
`endif

    always #5 clk = ~clk;

    data_access_unit #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .exe_valid         (exe_valid),
        .exe_Abortion      (exe_Abortion),
        .pipe_stall        (pipe_stall),
        .exe_out_Mem_read  (exe_out_Mem_read),
        .exe_out_Mem_write (exe_out_Mem_write),
        .exe_Store_type    (exe_Store_type),
        .exe_ALU_out       (exe_ALU_out),
        .exe_rdata2        (exe_rdata2),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wstrb        (data_wstrb),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .mem_in_data       (mem_in_data),
        .data_wait         (data_wait)
`ifdef ADDR_ERR_CHECK_EN
        ,
        .exe_Load_type     (exe_Load_type),
        .mem_addr_err      (mem_addr_err)
`endif
    );

    typedef struct {
        logic        ld;
        logic [2:0]  st;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] daddr;
    } vec_t;

    localparam int NV = 16;
    vec_t        vt[NV];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ld, input logic [2:0] st, input logic [31:0] addr,
                                input logic [31:0] rt, input logic [31:0] rdata, input logic [1:0] size,
                                input logic [3:0] wstrb, input logic [31:0] wdata, input logic [31:0] daddr);
        vec_t v;
        v.ld = ld; v.st = st; v.addr = addr; v.rt = rt; v.rdata = rdata;
        v.size = size; v.wstrb = wstrb; v.wdata = wdata; v.daddr = daddr;
        return v;
    endfunction

    task automatic drive_access(input logic ld, input logic [2:0] st, input logic [31:0] addr,
                                input logic [31:0] rt);
        exe_valid         = 1'b1;
        exe_out_Mem_read  = ld;
        exe_out_Mem_write = ~ld;
        exe_Store_type    = st;
        exe_ALU_out       = addr;
        exe_rdata2        = rt;
`ifdef ADDR_ERR_CHECK_EN
        exe_Load_type     = LT_LW;
`endif
    endtask

    task automatic drop_access();
        exe_valid         = 1'b0;
        exe_out_Mem_read  = 1'b0;
        exe_out_Mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(1'b0, ST_SW,  32'h0000_1000, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 2'd2, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1000);
        vt[1]  = mk(1'b0, ST_SB,  32'h0000_1003, 32'h0000_00AB, 32'hBAD0_BAD0, 2'd0, 4'b1000, 32'hABAB_ABAB, 32'h0000_1003);
        vt[2]  = mk(1'b0, ST_SWL, 32'h0000_2001, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b0011, 32'h0000_1122, 32'h0000_2000);
        vt[3]  = mk(1'b0, ST_SWR, 32'h0000_2002, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b1100, 32'h3344_0000, 32'h0000_2000);
        vt[4]  = mk(1'b0, ST_SH,  32'h0000_4002, 32'h0000_BEEF, 32'hBAD0_BAD0, 2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_4002);
        vt[5]  = mk(1'b0, ST_SH,  32'h0000_4000, 32'h1234_5678, 32'hBAD0_BAD0, 2'd1, 4'b0011, 32'h5678_5678, 32'h0000_4000);
        vt[6]  = mk(1'b0, ST_SB,  32'h0000_5001, 32'h0000_0099, 32'hBAD0_BAD0, 2'd0, 4'b0010, 32'h9999_9999, 32'h0000_5001);
        vt[7]  = mk(1'b0, ST_SB,  32'h0000_5000, 32'h1234_567E, 32'hBAD0_BAD0, 2'd0, 4'b0001, 32'h7E7E_7E7E, 32'h0000_5000);
        vt[8]  = mk(1'b0, ST_SWL, 32'h0000_6000, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b0001, 32'h0000_0011, 32'h0000_6000);
        vt[9]  = mk(1'b0, ST_SWL, 32'h0000_6002, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b0111, 32'h0011_2233, 32'h0000_6000);
        vt[10] = mk(1'b0, ST_SWL, 32'h0000_6003, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b1111, 32'h1122_3344, 32'h0000_6000);
        vt[11] = mk(1'b0, ST_SWR, 32'h0000_6001, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b1110, 32'h2233_4400, 32'h0000_6000);
        vt[12] = mk(1'b0, ST_SWR, 32'h0000_6003, 32'h1122_3344, 32'hBAD0_BAD0, 2'd2, 4'b1000, 32'h4400_0000, 32'h0000_6000);
        vt[13] = mk(1'b0, ST_SWR, 32'h0000_7000, 32'hA5A5_1234, 32'hBAD0_BAD0, 2'd2, 4'b1111, 32'hA5A5_1234, 32'h0000_7000);
        vt[14] = mk(1'b1, ST_SW,  32'h0000_8000, 32'h0,         32'h0123_4567, 2'd2, 4'b0000, 32'h0,         32'h0000_8000);
        vt[15] = mk(1'b1, ST_SW,  32'h0000_FFFC, 32'h0,         32'h89AB_CDEF, 2'd2, 4'b0000, 32'h0,         32'h0000_FFFC);

        rst = 1'b1;
        exe_Abortion = 1'b0;
        pipe_stall = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;
        drive_access(1'b0, ST_SW, '0, '0);
        drop_access();
        exp_mem = '0;

        tick();
        tick();
        chk("rst_req",   {31'b0, data_req}, 32'h0);
        chk("rst_wr",    {31'b0, data_wr}, 32'h0);
        chk("rst_size",  {30'b0, data_size}, 32'h0);
        chk("rst_addr",  data_addr, 32'h0);
        chk("rst_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_mem",   mem_in_data, 32'h0);
        chk("rst_wait",  {31'b0, data_wait}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive_access(vt[i].ld, vt[i].st, vt[i].addr, vt[i].rt);
            #1;
            chk($sformatf("v%0d_wait_idle", i), {31'b0, data_wait}, 32'h1);
            tick();
            chk($sformatf("v%0d_req", i),   {31'b0, data_req}, 32'h1);
            chk($sformatf("v%0d_wr", i),    {31'b0, data_wr}, {31'b0, ~vt[i].ld});
            chk($sformatf("v%0d_size", i),  {30'b0, data_size}, {30'b0, vt[i].size});
            chk($sformatf("v%0d_addr", i),  data_addr, vt[i].daddr);
            chk($sformatf("v%0d_wstrb", i), {28'b0, data_wstrb}, {28'b0, vt[i].wstrb});
            if (!vt[i].ld) chk($sformatf("v%0d_wdata", i), data_wdata, vt[i].wdata);
            data_addr_ok = 1'b1;
            tick();
            data_addr_ok = 1'b0;
            chk($sformatf("v%0d_req_drop", i), {31'b0, data_req}, 32'h0);
            chk($sformatf("v%0d_wait_hold", i), {31'b0, data_wait}, 32'h1);
            data_data_ok = 1'b1;
            data_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_wait_dok", i), {31'b0, data_wait}, 32'h0);
            drop_access();
            tick();
            data_data_ok = 1'b0;
            if (vt[i].ld) exp_mem = vt[i].rdata;
            chk($sformatf("v%0d_mem", i), mem_in_data, exp_mem);
            chk($sformatf("v%0d_idle_req", i), {31'b0, data_req}, 32'h0);
        end

        // SW with addr_ok delayed two cycles: request held for three cycles
        drive_access(1'b0, ST_SW, 32'h0000_1000, 32'hDEAD_BEEF);
        tick();
        chk("A_req1", {31'b0, data_req}, 32'h1);
        tick();
        chk("A_req2", {31'b0, data_req}, 32'h1);
        chk("A_wait_req", {31'b0, data_wait}, 32'h1);
        tick();
        chk("A_req3", {31'b0, data_req}, 32'h1);
        chk("A_wstrb", {28'b0, data_wstrb}, 32'hF);
        chk("A_wdata", data_wdata, 32'hDEAD_BEEF);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("A_req_drop", {31'b0, data_req}, 32'h0);
        chk("A_wait_wait", {31'b0, data_wait}, 32'h1);
        data_data_ok = 1'b1;
        data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("A_wait_dok", {31'b0, data_wait}, 32'h0);
        drop_access();
        tick();
        data_data_ok = 1'b0;
        chk("A_mem_keep", mem_in_data, exp_mem);
        chk("A_wait_end", {31'b0, data_wait}, 32'h0);

        // LW completing under pipe_stall sits in DONE without re-requesting
`ifdef ADDR_ERR_CHECK_EN
        drive_access(1'b1, ST_SW, 32'h0000_3004, 32'h0);
`else
        drive_access(1'b1, ST_SW, 32'h0000_3006, 32'h0);
`endif
        tick();
        chk("B_addr", data_addr, 32'h0000_3004);
        chk("B_wr", {31'b0, data_wr}, 32'h0);
        chk("B_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("B_size", {30'b0, data_size}, 32'h2);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        pipe_stall = 1'b1;
        tick();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        exp_mem = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("B_done_mem%0d", k), mem_in_data, exp_mem);
            chk($sformatf("B_done_req%0d", k), {31'b0, data_req}, 32'h0);
            chk($sformatf("B_done_wait%0d", k), {31'b0, data_wait}, 32'h0);
            tick();
        end
        pipe_stall = 1'b0;
        drop_access();
        tick();
        chk("B_exit_req", {31'b0, data_req}, 32'h0);
        chk("B_exit_mem", mem_in_data, exp_mem);

        // abort while request is pending and not yet accepted
        drive_access(1'b0, ST_SW, 32'h0000_A000, 32'h1111_1111);
        tick();
        chk("C_req", {31'b0, data_req}, 32'h1);
        exe_Abortion = 1'b1;
        tick();
        chk("C_req_drop", {31'b0, data_req}, 32'h0);
        exe_Abortion = 1'b0;
        drop_access();
        #1;
        chk("C_idle_wait", {31'b0, data_wait}, 32'h0);
        tick();
        chk("C_idle_req", {31'b0, data_req}, 32'h0);

        // abort after acceptance: transfer completes, load data discarded, back to IDLE
        drive_access(1'b1, ST_SW, 32'h0000_9000, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        exe_Abortion = 1'b1;
        drop_access();
        tick();
        exe_Abortion = 1'b0;
        chk("D_req", {31'b0, data_req}, 32'h0);
        chk("D_wait_hold", {31'b0, data_wait}, 32'h1);
        tick();
        data_data_ok = 1'b1;
        data_rdata = 32'h5555_5555;
        pipe_stall = 1'b1;
        #1;
        chk("D_wait_dok", {31'b0, data_wait}, 32'h0);
        tick();
        data_data_ok = 1'b0;
        chk("D_mem_keep", mem_in_data, exp_mem);
        drive_access(1'b1, ST_SW, 32'h0000_9100, 32'h0);
        #1;
        chk("D_idle_after", {31'b0, data_wait}, 32'h1);
        pipe_stall = 1'b0;

        // addr_ok and data_ok in the same cycle
        tick();
        chk("F_req", {31'b0, data_req}, 32'h1);
        chk("F_addr", data_addr, 32'h0000_9100);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h600D_F00D;
        #1;
        chk("F_wait_dok", {31'b0, data_wait}, 32'h0);
        drop_access();
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        exp_mem = 32'h600D_F00D;
        chk("F_mem", mem_in_data, exp_mem);
        chk("F_req_end", {31'b0, data_req}, 32'h0);
        chk("F_wait_end", {31'b0, data_wait}, 32'h0);

        // reset while waiting for data_ok
        drive_access(1'b0, ST_SW, 32'h0000_1000, 32'h1234_5678);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        rst = 1'b1;
        drop_access();
        tick();
        rst = 1'b0;
        exp_mem = '0;
        chk("E_req",   {31'b0, data_req}, 32'h0);
        chk("E_wr",    {31'b0, data_wr}, 32'h0);
        chk("E_size",  {30'b0, data_size}, 32'h0);
        chk("E_addr",  data_addr, 32'h0);
        chk("E_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("E_wdata", data_wdata, 32'h0);
        chk("E_mem",   mem_in_data, exp_mem);
        chk("E_wait",  {31'b0, data_wait}, 32'h0);
        tick();
        chk("E_idle_wait", {31'b0, data_wait}, 32'h0);

`ifdef ADDR_ERR_CHECK_EN
        // misaligned halfword store is suppressed and flagged for one cycle
        drive_access(1'b0, ST_SH, 32'h0000_1001, 32'h0000_BEEF);
        tick();
        chk("G_req", {31'b0, data_req}, 32'h0);
        chk("G_err", {31'b0, mem_addr_err}, 32'h1);
        drop_access();
        tick();
        chk("G_err_clr", {31'b0, mem_addr_err}, 32'h0);
        chk("G_req_clr", {31'b0, data_req}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
